// File: rtl/mac_seq_pkg.sv
// Shared constants for the MAC Wishbone sequencer: register offsets, CTRL/STATUS
// bit positions, FSM state encodings and a byte-lane merge helper.
package mac_seq_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_OP_AB  = 3'd2;
  localparam logic [2:0] REG_OP_C   = 3'd3;
  localparam logic [2:0] REG_RESULT = 3'd4;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  localparam int STAT_OVF = 16;
  localparam int STAT_UDF = 17;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  // Replace only the byte lanes selected by sel.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0] sel);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers; clear has priority over push/pop,
// a push while full and a pop while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mac_wb_sequencer.sv
// Wishbone front end that queues operand sets for the FFPMAC, issues them one at
// a time, waits out the MAC latency and queues the results for firmware readback.
module mac_wb_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic [31:0] mac_c,
  output logic [1:0]  mac_rnd,
  input  logic [31:0] mac_result,
  output logic        irq,
  output logic [1:0]  dbg_state
);
  localparam int CW = $clog2(LAT) + 1;
  localparam int QW = $clog2(DEPTH) + 1;

  // Handshake: a request is accepted when cyc&stb are high and ack is low;
  // ack follows one cycle later for exactly one cycle, together with read data
  // and all register side effects.
  logic        acc, wr, rd;
  logic [2:0]  reg_sel;
  logic        run, irq_en, ovf, udf;
  logic [31:0] op_ab;
  logic [1:0]  state;
  logic [CW-1:0] cnt;
  logic        flush, op_push, op_pop, res_push, res_pop;
  logic [63:0] opq_head;
  logic [31:0] resq_head, rdata_next;
  logic        opq_full, opq_empty, resq_full, resq_empty;
  logic [QW-1:0] opq_cnt, resq_cnt;
  logic [28:0] unused_adr;

  assign unused_adr = {wbs_adr_i[31:5], wbs_adr_i[1:0]};
  assign acc     = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
  assign wr      = acc && wbs_we_i;
  assign rd      = acc && !wbs_we_i;
  assign reg_sel = wbs_adr_i[4:2];

  assign flush    = wr && reg_sel == REG_CTRL && wbs_sel_i[0] && wbs_dat_i[CTRL_FLUSH];
  assign op_push  = wr && reg_sel == REG_OP_C;
  assign res_pop  = rd && reg_sel == REG_RESULT;
  assign op_pop   = (state == S_ISSUE);
  assign res_push = (state == S_CAPTURE) && !resq_full;
  assign dbg_state = state;

  sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_opq (
    .clk(wb_clk_i), .rst_n(wb_rstn_i), .clear(flush),
    .push(op_push), .pop(op_pop),
    .din({op_ab, merge_bytes(32'h0, wbs_dat_i, wbs_sel_i)}),
    .dout(opq_head), .full(opq_full), .empty(opq_empty), .count(opq_cnt)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_resq (
    .clk(wb_clk_i), .rst_n(wb_rstn_i), .clear(flush),
    .push(res_push), .pop(res_pop),
    .din(mac_result),
    .dout(resq_head), .full(resq_full), .empty(resq_empty), .count(resq_cnt)
  );

  always_comb begin
    rdata_next = '0;
    case (reg_sel)
      REG_CTRL:   rdata_next = {26'b0, mac_rnd, 2'b00, irq_en, run};
      REG_STATUS: rdata_next = {14'b0, udf, ovf, 4'(resq_cnt), 4'(opq_cnt), 3'b0,
                                resq_empty, resq_full, opq_empty, opq_full,
                                state != S_IDLE};
      REG_OP_AB:  rdata_next = op_ab;
      REG_RESULT: rdata_next = resq_empty ? 32'h0 : resq_head;
      default:    rdata_next = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      run       <= 1'b0;
      irq_en    <= 1'b0;
      mac_rnd   <= 2'b01;
      op_ab     <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= rd ? rdata_next : 32'h0;
      irq       <= irq_en && !resq_empty;
      if (wr && reg_sel == REG_CTRL && wbs_sel_i[0]) begin
        run     <= wbs_dat_i[CTRL_RUN];
        irq_en  <= wbs_dat_i[CTRL_IRQ_EN];
        mac_rnd <= wbs_dat_i[5:4];
      end
      if (wr && reg_sel == REG_OP_AB)
        op_ab <= merge_bytes(op_ab, wbs_dat_i, wbs_sel_i);
      if (op_push && opq_full)
        ovf <= 1'b1;
      else if (wr && reg_sel == REG_STATUS && wbs_sel_i[2] && wbs_dat_i[STAT_OVF])
        ovf <= 1'b0;
      if (res_pop && resq_empty)
        udf <= 1'b1;
      else if (wr && reg_sel == REG_STATUS && wbs_sel_i[2] && wbs_dat_i[STAT_UDF])
        udf <= 1'b0;
    end
  end

  // Operands stay registered from ISSUE until the next ISSUE, so a stall in
  // CAPTURE keeps the MAC output valid.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      mac_a <= '0;
      mac_b <= '0;
      mac_c <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:
          if (run && !opq_empty) state <= S_ISSUE;
        S_ISSUE: begin
          {mac_b, mac_a, mac_c} <= opq_head;
          cnt   <= CW'(LAT - 1);
          state <= S_WAIT;
        end
        S_WAIT:
          if (cnt == '0) state <= S_CAPTURE;
          else           cnt   <= cnt - 1'b1;
        S_CAPTURE:
          if (!resq_full) state <= (run && !opq_empty) ? S_ISSUE : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_wb_sequencer.sv
// Directed bench for mac_wb_sequencer: register vector table, then hand-written
// sequences for issue timing, overflow, backpressure, flush and async reset.
module tb_mac_wb_sequencer;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  localparam logic [31:0] A_CTRL = 32'h00, A_STATUS = 32'h04, A_OP_AB = 32'h08;
  localparam logic [31:0] A_OP_C = 32'h0C, A_RESULT = 32'h10;
  localparam logic [1:0]  S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_CAPTURE = 2'd3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [15:0] mac_a, mac_b;
  logic [31:0] mac_c, mac_result;
  logic [1:0]  mac_rnd, dbg_state;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // Stand-in MAC: result is valid only once operands have been stable LAT cycles.
  logic [63:0] prev_ops = '0;
  int          stable = 0;
  assign mac_result = (stable >= LAT) ? ({mac_b, mac_a} + mac_c) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    #1;
    if ({mac_b, mac_a, mac_c} != prev_ops) begin
      prev_ops = {mac_b, mac_a, mac_c};
      stable   = 0;
    end else begin
      stable++;
    end
  end

  always #5 clk = ~clk;

  mac_wb_sequencer #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_rnd(mac_rnd),
    .mac_result(mac_result), .irq(irq), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
    int n;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    n = 0;
    r = '0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 10);
    if (!ack) begin
      total++; bad++;
      $display("FAIL wb_ack_timeout: adr %h no ack after %0d cycles", a, n);
    end
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    wb_access(1'b0, a, 32'h0, 4'hF, r);
  endtask

  task automatic push_op(input logic [31:0] ab, input logic [31:0] c, input logic dropped);
    wb_write(A_OP_AB, ab);
    wb_write(A_OP_C, c);
    if (!dropped) exp_q.push_back(ab + c);
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, input string name);
    int n = 0;
    while (dbg_state != s && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {30'b0, dbg_state}, {30'b0, s});
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] r;
    int issue_cyc[4];
    int n_issue;

    vecs[0]  = '{1'b0, A_CTRL,   32'h0,        4'hF, 32'h0000_0010};
    vecs[1]  = '{1'b0, A_STATUS, 32'h0,        4'hF, 32'h0000_0014};
    vecs[2]  = '{1'b0, A_OP_AB,  32'h0,        4'hF, 32'h0};
    vecs[3]  = '{1'b0, 32'h14,   32'h0,        4'hF, 32'h0};
    vecs[4]  = '{1'b1, A_OP_AB,  32'h1234_5678, 4'hF, 32'h0};
    vecs[5]  = '{1'b0, A_OP_AB,  32'h0,        4'hF, 32'h1234_5678};
    vecs[6]  = '{1'b1, A_OP_AB,  32'hFFFF_FFFF, 4'h3, 32'h0};
    vecs[7]  = '{1'b0, A_OP_AB,  32'h0,        4'hF, 32'h1234_FFFF};
    vecs[8]  = '{1'b1, A_CTRL,   32'h0000_0032, 4'hF, 32'h0};
    vecs[9]  = '{1'b0, A_CTRL,   32'h0,        4'hF, 32'h0000_0032};
    vecs[10] = '{1'b1, 32'h14,   32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[11] = '{1'b0, 32'h14,   32'h0,        4'hF, 32'h0};
    vecs[12] = '{1'b1, A_CTRL,   32'h0000_0036, 4'h0, 32'h0};
    vecs[13] = '{1'b0, A_CTRL,   32'h0,        4'hF, 32'h0000_0032};
    vecs[14] = '{1'b1, A_STATUS, 32'h0000_FFFF, 4'hF, 32'h0};
    vecs[15] = '{1'b0, A_STATUS, 32'h0,        4'hF, 32'h0000_0014};
    vecs[16] = '{1'b1, A_CTRL,   32'h0000_0010, 4'hF, 32'h0};
    vecs[17] = '{1'b0, A_CTRL,   32'h0,        4'hF, 32'h0000_0010};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_rnd", {30'b0, mac_rnd}, 32'h1);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
    rstn = 1'b1;
    @(posedge clk); #1;

    // Register vector table
    foreach (vecs[i]) begin
      wb_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, r);
      if (!vecs[i].w) chk($sformatf("vec%0d", i), r, vecs[i].exp);
    end
    chk("rnd_after_vec", {30'b0, mac_rnd}, 32'h1);
    wb_write(A_OP_AB, 32'h0);

    // Single op with latency tracking
    wb_write(A_OP_AB, 32'h4000_3C00);
    wb_write(A_OP_C, 32'h3F80_0000);
    wb_write(A_CTRL, 32'h13);
    wait_state(S_ISSUE, 10, "single_issue");
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk); #1;
      chk($sformatf("single_wait%0d", i), {30'b0, dbg_state}, {30'b0, S_WAIT});
      chk("single_mac_a", {16'b0, mac_a}, 32'h3C00);
      chk("single_mac_b", {16'b0, mac_b}, 32'h4000);
      chk("single_mac_c", mac_c, 32'h3F80_0000);
    end
    @(posedge clk); #1;
    chk("single_capture", {30'b0, dbg_state}, {30'b0, S_CAPTURE});
    @(posedge clk); #1;
    chk("single_idle", {30'b0, dbg_state}, {30'b0, S_IDLE});
    @(posedge clk); #1;
    chk("single_irq", {31'b0, irq}, 32'h1);
    wb_read(A_RESULT, r);
    chk("single_result", r, 32'h7F80_3C00);

    // Back-to-back: queue 4 then run
    wb_write(A_CTRL, 32'h12);
    for (int i = 0; i < 4; i++)
      push_op(32'h1111_0000 * (i + 1), 32'h0000_1000 + i, 1'b0);
    wb_write(A_CTRL, 32'h13);
    n_issue = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (dbg_state == S_ISSUE && n_issue < 4) begin
        issue_cyc[n_issue] = c;
        n_issue++;
      end
      if (n_issue == 4 && dbg_state == S_IDLE) break;
    end
    chk("b2b_issue_count", n_issue, 4);
    for (int k = 1; k < 4; k++)
      chk($sformatf("b2b_spacing%0d", k), issue_cyc[k] - issue_cyc[k-1], LAT + 2);
    wb_read(A_STATUS, r);
    chk("b2b_status", r, 32'h0000_400C);
    for (int k = 0; k < 4; k++) begin
      chk("b2b_irq_before_read", {31'b0, irq}, 32'h1);
      wb_read(A_RESULT, r);
      chk($sformatf("b2b_result%0d", k), r, exp_q.pop_front());
    end
    @(posedge clk); #1;
    chk("b2b_irq_after", {31'b0, irq}, 32'h0);

    // Operand overflow
    wb_write(A_CTRL, 32'h12);
    for (int i = 0; i < 5; i++)
      push_op(32'h2222_0000 + i, 32'h0000_0100 * (i + 1), i == 4);
    wb_read(A_STATUS, r);
    chk("ovf_status", r, 32'h0001_0412);
    wb_write(A_STATUS, 32'h0001_0000);
    wb_read(A_STATUS, r);
    chk("ovf_cleared", r, 32'h0000_0412);
    wb_write(A_CTRL, 32'h16);
    exp_q.delete();
    wb_read(A_STATUS, r);
    chk("flush_idle_status", r, 32'h0000_0014);

    // Result backpressure
    wb_write(A_CTRL, 32'h13);
    for (int i = 0; i < 6; i++)
      push_op(32'h3333_0000 + 32'h10 * i, 32'h0000_0007 + i, 1'b0);
    repeat (60) @(posedge clk);
    #1;
    chk("bp_stall_state", {30'b0, dbg_state}, {30'b0, S_CAPTURE});
    chk("bp_irq", {31'b0, irq}, 32'h1);
    wb_read(A_STATUS, r);
    chk("bp_status", r, 32'h0000_4109);
    wb_read(A_RESULT, r);
    chk("bp_result0", r, exp_q.pop_front());
    @(posedge clk); #1;
    chk("bp_resume_issue", {30'b0, dbg_state}, {30'b0, S_ISSUE});
    wait_state(S_CAPTURE, 20, "bp_second_stall");
    for (int k = 1; k < 6; k++) begin
      wb_read(A_RESULT, r);
      chk($sformatf("bp_result%0d", k), r, exp_q.pop_front());
    end
    chk("bp_queue_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    wb_read(A_STATUS, r);
    chk("bp_final_status", r, 32'h0000_0014);

    // Underflow
    wb_read(A_RESULT, r);
    chk("udf_data", r, 32'h0);
    wb_read(A_STATUS, r);
    chk("udf_status", r, 32'h0002_0014);
    wb_write(A_STATUS, 32'h0002_0000);
    wb_read(A_STATUS, r);
    chk("udf_cleared", r, 32'h0000_0014);

    // Flush during WAIT
    wb_write(A_CTRL, 32'h12);
    push_op(32'h4444_0001, 32'h5, 1'b0);
    push_op(32'h4444_0002, 32'h6, 1'b0);
    wb_write(A_CTRL, 32'h13);
    wait_state(S_WAIT, 10, "flush_reach_wait");
    wb_write(A_CTRL, 32'h17);
    exp_q.delete();
    chk("flush_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("flush_stays_idle", {30'b0, dbg_state}, {30'b0, S_IDLE});
    wb_read(A_STATUS, r);
    chk("flush_status", r, 32'h0000_0014);
    chk("flush_irq", {31'b0, irq}, 32'h0);
    wb_read(A_CTRL, r);
    chk("flush_ctrl_readback", r, 32'h0000_0013);

    // Async reset mid-WAIT
    wb_write(A_CTRL, 32'h33);
    push_op(32'h5555_0001, 32'h9, 1'b0);
    wait_state(S_CAPTURE, 20, "arst_first_capture");
    wait_state(S_IDLE, 5, "arst_first_idle");
    push_op(32'h5555_0002, 32'hA, 1'b0);
    wait_state(S_WAIT, 10, "arst_reach_wait");
    chk("arst_irq_before", {31'b0, irq}, 32'h1);
    chk("arst_rnd_before", {30'b0, mac_rnd}, 32'h3);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_mac_a", {16'b0, mac_a}, 32'h0);
    chk("arst_mac_b", {16'b0, mac_b}, 32'h0);
    chk("arst_mac_c", mac_c, 32'h0);
    chk("arst_rnd", {30'b0, mac_rnd}, 32'h1);
    chk("arst_irq", {31'b0, irq}, 32'h0);
    chk("arst_ack", {31'b0, ack}, 32'h0);
    chk("arst_dat", rdat, 32'h0);
    chk("arst_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    wb_read(A_CTRL, r);
    chk("arst_ctrl", r, 32'h0000_0010);
    wb_read(A_STATUS, r);
    chk("arst_status", r, 32'h0000_0014);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_wb_sequencer.md
# mac_wb_sequencer

Wishbone-slave front end that feeds the FFPMAC floating-point multiply-accumulate unit from the management SoC, so firmware can batch operands instead of driving them from logic-analyzer pins. Software pushes operand sets into an operand FIFO. An issue FSM presents each set to the MAC, holds it for the MAC's fixed latency, and captures the result into a result FIFO. Firmware reads results back over Wishbone, and the block can raise an interrupt when results are available.

## Interface
- `DEPTH`, 4 — entries in each of the operand FIFO and the result FIFO; power of two, ≥2.
- `LAT`, 3 — cycles from stable operands at the MAC until its `result` is valid; ≥1.
- `wb_clk_i` input 1 — single clock for the block and the MAC.
- `wb_rstn_i` input 1 — reset; asynchronous, active-low.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` input 1 each — Wishbone strobe, cycle and write-enable.
- `wbs_sel_i` input 4 — byte selects; writes honour byte lanes.
- `wbs_adr_i` input 32 — only `[4:2]` is decoded.
- `wbs_dat_i` input 32 — write data.
- `wbs_ack_o` output 1 — single-cycle acknowledge.
- `wbs_dat_o` output 32 — read data.
- `mac_a`, `mac_b` output 16 each — MAC operands A and B.
- `mac_c` output 32 — MAC addend C.
- `mac_rnd` output 2 — MAC rounding mode.
- `mac_result` input 32 — MAC result.
- `irq` output 1 — result-available interrupt.

## Operation
Register map (word offsets):
- **0x00 CTRL** (R/W)
  - bit0 `run`.
  - bit1 `irq_en`.
  - bit2 `flush`: write-1, self-clearing, reads 0.
  - bits[5:4] `rnd`: reset 2'b01; drives `mac_rnd`.
- **0x04 STATUS** (RO, except bits 16–17)
  - bit0 busy (FSM not IDLE).
  - bit1 opq_full, bit2 opq_empty.
  - bit3 resq_full, bit4 resq_empty.
  - [11:8] opq count, [15:12] resq count.
  - bit16 `ovf` sticky, bit17 `udf` sticky; both write-1-to-clear.
- **0x08 OP_AB** (R/W) — holding register {B[31:16], A[15:0]}.
- **0x0C OP_C** (WO) — a write pushes {OP_AB, wdata} into the operand FIFO.
  - If the FIFO is full, the push is dropped and `ovf` is set.
  - Fullness is evaluated before any same-cycle FSM pop.
- **0x10 RESULT** (RO) — a read pops the result FIFO head.
  - If empty, reads 0 and sets `udf`.
- Unmapped addresses read 0; writes to them are ignored.

FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- **IDLE → ISSUE** when `run` and operand FIFO non-empty.
- **ISSUE** (1 cycle): pop the head into the `mac_a/b/c` registers.
- **WAIT**: counter loads LAT-1 and decrements to 0; operands stay stable throughout.
- **CAPTURE**:
  - If the result FIFO is not full, push `mac_result`.
  - Then go to ISSUE if `run` and operand FIFO non-empty, else IDLE.
  - If the result FIFO is full, stall in CAPTURE with operands held. Nothing is lost.
- **`run` cleared mid-operation**: the current operation completes, then the FSM idles.
- **`flush`**: empties both FIFOs and forces the FSM to IDLE from any state; an in-flight result is discarded. `flush` beats a same-cycle push or pop.
- `irq` = `irq_en` & !resq_empty, registered.

## Timing
- Wishbone:
  - `wbs_ack_o` asserts the cycle after `cyc&stb` with ack low, for exactly 1 cycle.
  - Read data is registered and valid alongside ack.
  - Side effects (push, pop, W1C) occur in the ack cycle.
  - No back-to-back ack; minimum 2 cycles per access.
- Throughput: LAT+2 cycles per operation (ISSUE + LAT WAIT + CAPTURE) with no stalls.
- Reset values:
  - All outputs 0, except `mac_rnd` = 2'b01.
  - CTRL = 0x10; OP_AB = 0; FIFOs empty; FSM IDLE; `ovf`/`udf` = 0.
- Reset mid-operation: everything returns to reset values immediately (asynchronous).
- Pointer width is log2(DEPTH)+1; counts wrap naturally at DEPTH.

## Structure
- Package `mac_seq_pkg`: register offset constants, CTRL/STATUS bit indices, FSM state enum.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count/clear), instantiated twice:
  - operand FIFO, 64 bits wide;
  - result FIFO, 32 bits wide.
- The top level holds the register decode, ack logic, FSM and latency counter.

## Test plan
- **Single op.** Reset; write OP_AB=0x4000_3C00, OP_C=0x3F80_0000, CTRL=0x13.
  - `mac_a` = 0x3C00, `mac_b` = 0x4000, `mac_c` = 0x3F800000, held for LAT cycles.
  - The result is captured at cycle LAT+2 after ISSUE; `irq`=1; the RESULT read returns the model value.
- **Back-to-back.** Push 4 sets with `run`=0, then set `run`.
  - 4 ISSUE pulses, spaced LAT+2 cycles apart.
  - resq count = 4; 4 RESULT reads come back in order; `irq` drops after the last read.
- **Operand overflow.** Push 5 sets with `run`=0.
  - The 5th is dropped; STATUS bit16 = 1, count = 4.
  - Writing 0x10000 to STATUS clears bit16.
- **Result backpressure.** Push 6 sets, run, and don't read.
  - The FSM stalls in CAPTURE with resq_full.
  - One RESULT read → the stalled result is pushed the next cycle and the remaining op proceeds; no data is lost.
- **Underflow and flush.**
  - A RESULT read while empty returns 0 and sets bit17.
  - Flush asserted during WAIT → FSM IDLE, both counts 0, no result pushed.
- **Async reset.** Assert `wb_rstn_i`=0 mid-WAIT.
  - Outputs go to reset values immediately, without waiting for a clock edge; `mac_rnd` = 2'b01.
